// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding and a constant clog2 helper.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2, usable in parameter expressions; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: one-hot of the first set request bit at or above
// ptr, scanning upward and wrapping from N-1 back to 0. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (clog2(N) > 0) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int   idx;
    logic found;

    // Walk the N positions starting at ptr and keep only the first requester.
    always_comb begin
        // NOTE: every output of an always_comb gets a default before any
        // conditional assignment; otherwise the tool infers a latch.
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: a winner keeps the grant for up to
// max(weight,1) beats, then priority rotates to the channel after it.
module weighted_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int WW = 4,
    localparam int IW = (clog2(N) > 0) ? clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic [N*WW-1:0] weight_i,
    output logic [N-1:0]    gnt_o,
    output logic            gnt_valid_o,
    output logic [IW-1:0]   gnt_idx_o
);

    arb_state_e    state;
    arb_state_e    state_d;
    logic [WW-1:0] cnt;
    logic [WW-1:0] cnt_d;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_d;
    logic [N-1:0]  gnt_d;
    logic [IW-1:0] gnt_idx_d;
    logic          armed;

    logic [IW-1:0] release_ptr;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic [WW-1:0] pick_weight;
    logic [WW-1:0] load_weight;

    // On release the search starts just after the current owner, so the same
    // picker serves both the idle case (stored ptr) and the hand-over case.
    assign release_ptr = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + IW'(1);
    assign pick_ptr    = (state == ARB_GRANT) ? release_ptr : ptr;

    rr_pick #(
        .N  (N),
        .PW (IW)
    ) u_pick (
        .req (req_i),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    // Binary index of the picked channel and its weight; weight 0 counts as 1.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = IW'(i);
            end
        end
        pick_weight = weight_i[int'(pick_idx)*WW +: WW];
        load_weight = (pick_weight == '0) ? WW'(1) : pick_weight;
    end

    // Next-state logic: start a grant, count beats, or release and re-arbitrate.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ptr_d     = ptr;
        gnt_d     = gnt_o;
        gnt_idx_d = gnt_idx_o;
        unique case (state)
            ARB_IDLE: begin
                // The first edge after reset only arms the arbiter, so the
                // earliest grant appears after the second edge.
                if (armed && (req_i != '0)) begin
                    state_d   = ARB_GRANT;
                    gnt_d     = pick_gnt;
                    gnt_idx_d = pick_idx;
                    cnt_d     = load_weight;
                end
            end
            ARB_GRANT: begin
                if (req_i[gnt_idx_o] && (cnt > WW'(1))) begin
                    cnt_d = cnt - WW'(1);
                end else begin
                    ptr_d = release_ptr;
                    if (req_i != '0) begin
                        gnt_d     = pick_gnt;
                        gnt_idx_d = pick_idx;
                        cnt_d     = load_weight;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= ARB_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gnt_o     <= '0;
            gnt_idx_o <= '0;
            armed     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ptr       <= ptr_d;
            gnt_o     <= gnt_d;
            gnt_idx_o <= gnt_idx_d;
            armed     <= 1'b1;
        end
    end

    assign gnt_valid_o = |gnt_o;

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..16).
REQ-002 SHALL have parameter WW, default 4, meaning per-requester weight width in bits.
REQ-003 SHALL have port clk, input, 1, clock (rising edge).
REQ-004 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port req_i, input, N, per-requester request level; the requester holds it high while it has beats to send.
REQ-006 SHALL have port weight_i, input, N*WW, packed weights; channel k occupies bits [k*WW +: WW].
REQ-007 SHALL have port gnt_o, output, N, registered one-hot grant (all-zero when idle).
REQ-008 SHALL have port gnt_valid_o, output, 1, high when any grant bit is set.
REQ-009 SHALL have port gnt_idx_o, output, clog2(N), binary index of the granted channel (holds last value when idle).

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (channel k owns gnt_o).
REQ-011 In IDLE, on an edge with req_i != 0, SHALL move to GRANT for winner w; gnt_o[w] rises the next cycle (1-cycle request-to-grant latency).
REQ-012 Winner selection SHALL be the first set bit of req_i at or above pointer ptr, scanning upward and wrapping at N-1 to 0.
REQ-013 On grant start SHALL load the beat counter cnt with weight_i[w]; a weight of 0 SHALL be treated as 1; weight changes during a grant SHALL be ignored.
REQ-014 A beat is a cycle with gnt_o[k]=1 and req_i[k]=1.
REQ-015 In GRANT, on an edge with req_i[k]=1 and cnt>1, SHALL decrement cnt and hold the grant.
REQ-016 In GRANT, on an edge with req_i[k]=0 or cnt==1, SHALL release k, set ptr=(k+1) mod N, and arbitrate req_i in the same edge with the new ptr.
REQ-017 On release with any request present, gnt_o SHALL switch directly to the new winner with no idle cycle; with no request present, the FSM SHALL return to IDLE.
REQ-018 When only channel k requests at release, k SHALL be re-granted with a freshly loaded weight.
REQ-019 Ownership SHALL be limited to max(weight,1) consecutive beats, and any continuously requesting channel SHALL be granted within (N-1)*(2^WW-1)+1 cycles.
REQ-020 gnt_o SHALL be one-hot or zero at all times, and gnt_valid_o SHALL equal |gnt_o.

Reset
REQ-021 Asserting rst_n low SHALL asynchronously force IDLE, gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, cnt=0 and ptr=0.
REQ-022 Reset mid-grant SHALL drop the grant immediately; the first arbitration after reset SHALL use ptr=0.
REQ-023 The first grant SHALL occur no earlier than the second rising edge after rst_n deasserts.

Structure
REQ-024 A shared package arb_pkg SHALL hold the clog2 helper and FSM state encodings (ARB_IDLE, ARB_GRANT).
REQ-025 The rotating-priority selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; output one-hot), reusable by later arbiters.
REQ-026 All state (FSM, cnt, ptr, gnt_o, gnt_idx_o) SHALL live in weighted_rr_arbiter.

Verification
REQ-027 N=4, all weights 1, req_i=4'b1111 held: gnt_idx_o SHALL cycle 0,1,2,3,0, changing every cycle.
REQ-028 Weights {3,1,2,1} (ch0..3), req_i=4'b1111 held: grant SHALL be ch0 x3, ch1 x1, ch2 x2, ch3 x1, then repeat.
REQ-029 Only ch2 requests with weight 0: ch2 SHALL be re-granted every cycle and gnt_valid_o SHALL stay high.
REQ-030 ch1 granted with weight 5, req_i[1] drops after 2 beats while ch3 requests: gnt SHALL move to ch3 on the next edge, and ptr SHALL become 2.
REQ-031 rst_n pulsed low during a ch2 grant: gnt_o=0 immediately; after release with req_i=4'b1100, the first grant SHALL be ch2.
REQ-032 Random req_i/weights for 10k cycles: the one-hot invariant, the per-grant beat bound and the starvation bound of REQ-019 SHALL hold.
